banked_register_file: RTL

- Parametrised successor to the single-bank 32x32 register file.
- Holds separate integer and floating-point banks with a configurable number of synchronous read ports and one write port.
- Provides write-to-read bypass and a hardware clear sequencer that zeroes both banks after reset or on request.
- Sits in the decode stage of the modified MIPS pipeline, feeding operand latches for both the integer ALU and the FPU.

---
 rtl/banked_register_file.sv | 130 +++++++++++++
 1 files changed

// File: rtl/banked_register_file.sv
// Banked register file: separate integer and float banks, NUM_RD registered
// read ports, one write port, write-to-read bypass and a clear sequencer that
// zeroes both banks after reset or on request.
module banked_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  input  logic                     wr_en,
  input  logic                     wr_float,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD-1:0]        rd_float,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;

  logic [DATA_W-1:0] r_int_mem [DEPTH];
  logic [DATA_W-1:0] r_flt_mem [DEPTH];

  // Shared write port into both banks (either the clear sweep or the user write)
  logic              w_we_int;
  logic              w_we_flt;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  // A user write that actually lands in the array; only such writes bypass
  logic              w_wr_commit;

  // State register and clear index; the index wraps to 0 after the last entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) begin
        r_idx <= r_idx + ADDR_W'(1);
      end else if (clear_req) begin
        r_idx <= '0;
      end
    end
  end

  // Next state: sweep finishes on the last index, a request restarts it from READY
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_idx == ADDR_W'(DEPTH - 1)) w_state_next = S_READY;
      S_READY: if (clear_req) w_state_next = S_CLEAR;
      default: w_state_next = S_CLEAR;
    endcase
  end

  // Outputs of the FSM: ready flag and the array write port steering
  always_comb begin
    ready       = 1'b0;
    w_we_int    = 1'b0;
    w_we_flt    = 1'b0;
    w_mem_addr  = wr_addr;
    w_mem_data  = wr_data;
    w_wr_commit = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_we_int   = 1'b1;
        w_we_flt   = 1'b1;
        w_mem_addr = r_idx;
        w_mem_data = '0;
      end
      S_READY: begin
        ready = 1'b1;
        // Integer r0 is hardwired to zero, so writes to it never land
        w_wr_commit = wr_en && !clear_req && (wr_float || (wr_addr != '0));
        w_we_int    = w_wr_commit && !wr_float;
        w_we_flt    = w_wr_commit && wr_float;
      end
      default: ;
    endcase
  end

  // Bank storage: no reset, contents are zeroed by the sweep instead
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_we_int) r_int_mem[w_mem_addr] <= w_mem_data;
      if (w_we_flt) r_flt_mem[w_mem_addr] <= w_mem_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_rd_addr;
      logic [DATA_W-1:0] w_mem_q;
      logic              w_bypass;

      assign w_rd_addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_mem_q   = rd_float[gi] ? r_flt_mem[w_rd_addr] : r_int_mem[w_rd_addr];
      assign w_bypass  = w_wr_commit && (wr_float == rd_float[gi]) && (wr_addr == w_rd_addr);

      // Registered read with same-cycle write forwarding; data holds when idle
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data[gi*DATA_W +: DATA_W] <= '0;
          rd_valid[gi]                 <= 1'b0;
        end else if (ready && rd_en[gi]) begin
          rd_data[gi*DATA_W +: DATA_W] <= w_bypass ? wr_data : w_mem_q;
          rd_valid[gi]                 <= 1'b1;
        end else begin
          rd_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
